// File: rtl/miss_arbiter.sv
// miss_arbiter: I/D cache miss arbiter; fetches one 8-word block per grant and fills the owner.
// Rev 1.0. Optional round-robin conflict arbitration enabled by defining MISS_ARB_RR_EN.
`default_nettype none

module miss_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_miss_req,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss_req,
  input  logic [15:0] d_miss_addr,
  output logic        mem_en,
  output logic [15:0] mem_addr,
  input  logic        mem_data_valid,
  input  logic [15:0] mem_data_in,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic        i_fill_we,
  output logic        d_fill_we,
  output logic        i_fill_done,
  output logic        d_fill_done,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_issue_cnt;
  logic [2:0]  r_ret_cnt;
  logic [15:0] r_base;
  logic        r_owner;
  logic        w_any_req;
  logic        w_d_prio;
  logic        w_grant_d;
  logic        w_grant;
  logic        w_fill;

`ifdef MISS_ARB_RR_EN
  logic r_last_owner;

  // On conflict D wins only if I was the last owner.
  assign w_d_prio = ~r_last_owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_owner <= 1'b0;
    end else if (w_grant) begin
      r_last_owner <= w_grant_d;
    end
  end
`else
  assign w_d_prio = 1'b1;
`endif

  assign w_any_req = i_miss_req | d_miss_req;
  assign w_grant_d = d_miss_req & (~i_miss_req | w_d_prio);
  assign w_grant   = (r_state == IDLE) & w_any_req;
  assign w_fill    = mem_data_valid & ((r_state == ISSUE) | (r_state == DRAIN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_issue_cnt <= 3'd0;
      r_ret_cnt   <= 3'd0;
      r_base      <= 16'd0;
      r_owner     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_base      <= (w_grant_d ? d_miss_addr : i_miss_addr) & 16'hFFF0;
        r_owner     <= w_grant_d;
        r_issue_cnt <= 3'd0;
        r_ret_cnt   <= 3'd0;
      end else begin
        if (r_state == ISSUE) begin
          r_issue_cnt <= r_issue_cnt + 3'd1;
        end
        if (w_fill) begin
          r_ret_cnt <= r_ret_cnt + 3'd1;
        end
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_any_req) w_next = ISSUE;
      ISSUE: if (r_issue_cnt == 3'd7) w_next = DRAIN;
      // The last return can only arrive after issue has finished.
      DRAIN: if (w_fill && (r_ret_cnt == 3'd7)) w_next = DONE;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign mem_en      = (r_state == ISSUE);
  assign mem_addr    = mem_en ? (r_base + {12'd0, r_issue_cnt, 1'b0}) : 16'd0;
  assign fill_data   = w_fill ? mem_data_in : 16'd0;
  assign fill_word   = w_fill ? r_ret_cnt : 3'd0;
  assign i_fill_we   = w_fill & ~r_owner;
  assign d_fill_we   = w_fill & r_owner;
  assign i_fill_done = (r_state == DONE) & ~r_owner;
  assign d_fill_done = (r_state == DONE) & r_owner;
  assign busy        = (r_state != IDLE);
  assign owner       = r_owner;

endmodule

`default_nettype wire

// File: tb/tb_miss_arbiter.sv
// tb_miss_arbiter: directed self-checking bench for miss_arbiter with a 4-cycle memory model.
`default_nettype none

module tb_miss_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_miss_req, d_miss_req;
  logic [15:0] i_miss_addr, d_miss_addr;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic        mem_data_valid;
  logic [15:0] mem_data_in;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, busy, owner;

  int n_checks = 0;
  int n_errors = 0;

  logic        pv[4];
  logic [15:0] pa[4];

  miss_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss_req(i_miss_req), .i_miss_addr(i_miss_addr),
    .d_miss_req(d_miss_req), .d_miss_addr(d_miss_addr),
    .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_data_valid(mem_data_valid), .mem_data_in(mem_data_in),
    .fill_data(fill_data), .fill_word(fill_word),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, act, exp);
    end
  endtask

  // One clock: memory returns whatever was issued 4 cycles earlier, data = addr ^ 5A5A.
  task automatic step();
    logic        en;
    logic [15:0] a;
    en = mem_en;
    a  = mem_addr;
    @(posedge clk);
    #1;
    for (int k = 3; k > 0; k--) begin
      pv[k] = pv[k-1];
      pa[k] = pa[k-1];
    end
    pv[0] = en;
    pa[0] = a;
    mem_data_valid = pv[3];
    mem_data_in    = pv[3] ? (pa[3] ^ 16'h5A5A) : 16'h0000;
    #1;
  endtask

  // Called in the IDLE cycle where the request is presented; ends in the DONE cycle.
  task automatic expect_fill(input logic d, input logic [15:0] base,
                             input logic drop_i, input logic drop_d, input logic corrupt);
    logic        e_en, e_fill;
    logic [15:0] e_addr, e_data;
    logic [2:0]  e_word;
    for (int t = 1; t <= 13; t++) begin
      step();
      e_en   = (t >= 1) && (t <= 8);
      e_addr = e_en ? base + 16'(2 * (t - 1)) : 16'h0000;
      e_fill = (t >= 5) && (t <= 12);
      e_word = e_fill ? 3'(t - 5) : 3'd0;
      e_data = e_fill ? ((base + 16'(2 * (t - 5))) ^ 16'h5A5A) : 16'h0000;
      check("mem", {mem_en, mem_addr}, {e_en, e_addr});
      check("fill", {i_fill_we, d_fill_we, fill_word, fill_data},
            {e_fill & ~d, e_fill & d, e_word, e_data});
      check("ctl", {i_fill_done, d_fill_done, busy, owner},
            {(t == 13) & ~d, (t == 13) & d, 1'b1, d});
      if (corrupt && t == 3) begin
        d_miss_addr = 16'hFFFF;
        i_miss_addr = 16'hFFFF;
        i_miss_req  = 1'b1;
      end
      if (t == 13) begin
        if (drop_i) i_miss_req = 1'b0;
        if (drop_d) d_miss_req = 1'b0;
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check(tag, {busy, mem_en, mem_addr, i_fill_we, d_fill_we, i_fill_done, d_fill_done}, 64'd0);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      pv[k] = 1'b0;
      pa[k] = 16'h0000;
    end
    rst_n = 1'b0;
    i_miss_req = 1'b0; d_miss_req = 1'b0;
    i_miss_addr = 16'h0000; d_miss_addr = 16'h0000;
    mem_data_valid = 1'b0; mem_data_in = 16'h0000;
    repeat (3) @(posedge clk);
    #2;
    check("reset_outs", {mem_en, mem_addr, fill_data, fill_word, i_fill_we, d_fill_we,
                         i_fill_done, d_fill_done, busy, owner}, 64'd0);
    rst_n = 1'b1;
    step();
    step();

    // Single I miss, unaligned address.
    i_miss_req = 1'b1; i_miss_addr = 16'h1236;
    expect_fill(1'b0, 16'h1230, 1'b1, 1'b1, 1'b0);
    step();
    check_idle("idle_after_i");

`ifdef MISS_ARB_RR_EN
    // Both held continuously: alternating grants starting with D.
    d_miss_req = 1'b1; d_miss_addr = 16'h0040;
    i_miss_req = 1'b1; i_miss_addr = 16'h2000;
    expect_fill(1'b1, 16'h0040, 1'b0, 1'b0, 1'b0);
    step();
    check_idle("rr_idle1");
    expect_fill(1'b0, 16'h2000, 1'b0, 1'b0, 1'b0);
    step();
    check_idle("rr_idle2");
    expect_fill(1'b1, 16'h0040, 1'b0, 1'b0, 1'b0);
    step();
    check_idle("rr_idle3");
    expect_fill(1'b0, 16'h2000, 1'b1, 1'b1, 1'b0);
    step();
`else
    // Conflict: D wins, I is granted in the IDLE cycle after d_fill_done.
    d_miss_req = 1'b1; d_miss_addr = 16'h0040;
    i_miss_req = 1'b1; i_miss_addr = 16'h2000;
    expect_fill(1'b1, 16'h0040, 1'b0, 1'b1, 1'b0);
    step();
    check_idle("fp_idle");
    expect_fill(1'b0, 16'h2000, 1'b1, 1'b1, 1'b0);
    step();
`endif
    check_idle("idle_after_conflict");

    // Request/address changes while busy must not disturb the transfer.
    d_miss_req = 1'b1; d_miss_addr = 16'h4568;
    expect_fill(1'b1, 16'h4560, 1'b1, 1'b1, 1'b1);
    step();
    check_idle("idle_after_corrupt");

    // Top-of-memory block, then a stray return while idle.
    i_miss_req = 1'b1; i_miss_addr = 16'hFFF5;
    expect_fill(1'b0, 16'hFFF0, 1'b1, 1'b1, 1'b0);
    step();
    mem_data_valid = 1'b1;
    mem_data_in    = 16'hBEEF;
    #1;
    check("stray", {i_fill_we, d_fill_we, fill_word, fill_data, busy, mem_en}, 64'd0);
    step();
    check_idle("after_stray");

    // Reset in cycle 7 of a fill.
    i_miss_req = 1'b1; i_miss_addr = 16'h3000;
    repeat (7) step();
    check("pre_rst", {mem_en, mem_addr, busy}, {1'b1, 16'h300C, 1'b1});
    rst_n = 1'b0;
    i_miss_req = 1'b0;
    #1;
    check("rst_now", {busy, mem_en, mem_addr, i_fill_we, d_fill_we}, 64'd0);
    step();
    check("rst_hold", {mem_en, mem_addr, fill_data, fill_word, i_fill_we, d_fill_we,
                       i_fill_done, d_fill_done, busy, owner}, 64'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("late_ret", {i_fill_we, d_fill_we, fill_data, i_fill_done, d_fill_done, busy}, 64'd0);
    end

    // Normal operation resumes after the aborted transfer.
    i_miss_req = 1'b1; i_miss_addr = 16'h0018;
    expect_fill(1'b0, 16'h0010, 1'b1, 1'b1, 1'b0);
    step();
    check_idle("final_idle");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
